count_sig_analyzer: RTL and testbench
=====================================

COUNT_SIG_ANALYZER -- requirements
Module: count_sig_analyzer

Interface
REQ-001 SHALL have parameter TEST_CYCLES, default 16, meaning the number of RUN cycles compressed, legal range 1..65535.
REQ-002 SHALL have parameter GOLDEN_SIG, default 8'h00, meaning the expected 8-bit signature.
REQ-003 SHALL have parameter SEED, default 8'h00, meaning the MISR value loaded at test start.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-005 SHALL have port rst, input, 1 bit: asynchronous reset, active-low (asserted when 0).
REQ-006 SHALL have port start, input, 1 bit: request to begin one test run.
REQ-007 SHALL have port count, input, 4 bits: counter value from the upstream counter.
REQ-008 SHALL have port co, input, 1 bit: carry-out from the upstream counter.
REQ-009 SHALL have port cnt_en, output, 1 bit: drives the counter en input.
REQ-010 SHALL have port cnt_clk_en, output, 1 bit: drives the counter clkEn input.
REQ-011 SHALL have port busy, output, 1 bit: high in LOAD, RUN and COMPARE.
REQ-012 SHALL have port done, output, 1 bit: high in DONE.
REQ-013 SHALL have port pass, output, 1 bit: compare result, meaningful while done=1.
REQ-014 SHALL have port signature, output, 8 bits: current MISR contents.

Function
REQ-015 SHALL implement FSM states IDLE, LOAD, RUN, COMPARE, DONE.
REQ-016 Transitions SHALL be: IDLE -start-> LOAD; LOAD -> RUN after 1 cycle; RUN -> COMPARE after exactly TEST_CYCLES cycles; COMPARE -> DONE after 1 cycle; DONE -start-> LOAD; otherwise hold.
REQ-017 LOAD SHALL set signature=SEED and clear the 16-bit run-cycle counter.
REQ-018 cnt_en and cnt_clk_en SHALL be 1 only in RUN, driven from registered state with no combinational path from start.
REQ-019 Each RUN cycle SHALL update the MISR as next = {sig[6:0],0} XOR (sig[7] ? 8'h1D : 8'h00) XOR {3'b000, cap_co, count}, where cap_co is defined in Configuration; polynomial x^8+x^4+x^3+x^2+1.
REQ-020 The MISR SHALL sample count/co in the same cycle as the update edge; the first sample is taken on the first RUN edge.
REQ-021 COMPARE SHALL register pass = (signature == GOLDEN_SIG); signature SHALL hold from COMPARE until the next LOAD.
REQ-022 start SHALL be ignored in LOAD, RUN and COMPARE.
REQ-023 start in DONE SHALL clear done and pass on entering LOAD.
REQ-024 The MISR SHALL never change outside LOAD and RUN.

Reset
REQ-025 rst=0 SHALL immediately force state=IDLE, with cnt_en, cnt_clk_en, busy, done and pass all 0, signature=8'h00 and the cycle counter=0.
REQ-026 Reset asserted mid-run SHALL abort the run, with no partial result retained.
REQ-027 After rst returns to 1, the block SHALL remain in IDLE until start.

Configuration
REQ-028 Macro MISR_CO_CAPTURE_EN SHALL control carry capture: when defined, cap_co=co (bit 4 of the MISR input); when undefined, cap_co=0 and co is unused.

Verification
REQ-029 Reset: rst=0 during any state -> all outputs 0 and signature=8'h00 in the same cycle; IDLE after release.
REQ-030 Zero stream: TEST_CYCLES=4, count=0, co=0, start pulse -> cnt_en high exactly 4 cycles, then busy=0, done=1, pass=1, signature=8'h00.
REQ-031 Cancel: TEST_CYCLES=2, count 4'h5 then 4'hA -> signature 8'h05 then 8'h00; pass=1. Mismatch: TEST_CYCLES=1, count=4'h5 -> signature 8'h05, pass=0, done=1.
REQ-032 Carry: TEST_CYCLES=1, count=0, co=1 -> signature 8'h10 with MISR_CO_CAPTURE_EN defined, 8'h00 without.
REQ-033 Reset mid-run: rst=0 on RUN cycle 3 of 16 -> outputs cleared; new start gives a full 16-cycle run with the correct signature.
REQ-034 start pulses during RUN -> no effect on run length or signature; start in DONE -> done/pass cleared, new run begins.

Source files
------------

// File: rtl/count_sig_analyzer.sv
// count_sig_analyzer: runs an upstream counter for TEST_CYCLES cycles, compresses count/co into an 8-bit MISR, compares to GOLDEN_SIG.
// Optional macro MISR_CO_CAPTURE_EN folds the counter carry-out into MISR input bit 4.
module count_sig_analyzer #(
    parameter int         TEST_CYCLES = 16,
    parameter logic [7:0] GOLDEN_SIG  = 8'h00,
    parameter logic [7:0] SEED        = 8'h00
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [3:0] count,
    input  logic       co,
    output logic       cnt_en,
    output logic       cnt_clk_en,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [7:0] signature
);
    typedef enum logic [2:0] {IDLE, LOAD, RUN, COMPARE, DONE} state_t;
    localparam logic [15:0] LAST = 16'(TEST_CYCLES - 1);
    state_t      r_state, w_next;
    logic [15:0] r_cyc;
    logic [7:0]  r_sig, w_misr;
    logic        r_pass, w_cap_co;
`ifdef MISR_CO_CAPTURE_EN
    assign w_cap_co = co;
`else
    assign w_cap_co = 1'b0 & co;
`endif
    assign w_misr = {r_sig[6:0], 1'b0} ^ (r_sig[7] ? 8'h1D : 8'h00) ^ {3'b000, w_cap_co, count};
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= IDLE;
        else      r_state <= w_next;
    end
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = start ? LOAD : IDLE;
            LOAD:    w_next = RUN;
            RUN:     w_next = (r_cyc == LAST) ? COMPARE : RUN;
            COMPARE: w_next = DONE;
            DONE:    w_next = start ? LOAD : DONE;
            default: w_next = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sig  <= 8'h00;
            r_cyc  <= 16'h0000;
            r_pass <= 1'b0;
        end else begin
            if (r_state == LOAD) begin
                r_sig <= SEED;
                r_cyc <= 16'h0000;
            end else if (r_state == RUN) begin
                r_sig <= w_misr;
                r_cyc <= r_cyc + 16'h0001;
            end
            // pass drops on the same edge that re-enters LOAD
            if (r_state == COMPARE)  r_pass <= (r_sig == GOLDEN_SIG);
            else if (w_next == LOAD) r_pass <= 1'b0;
        end
    end
    assign cnt_en     = (r_state == RUN);
    assign cnt_clk_en = (r_state == RUN);
    assign busy       = (r_state == LOAD) || (r_state == RUN) || (r_state == COMPARE);
    assign done       = (r_state == DONE);
    assign pass       = r_pass;
    assign signature  = r_sig;
endmodule

// File: tb/tb_count_sig_analyzer.sv
// tb_count_sig_analyzer: four analyzers (TEST_CYCLES 4/2/1/16) driven by directed runs, scoreboard of expected signature/pass.
module tb_count_sig_analyzer;
    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] count;
    logic       co;
    logic       start_i  [4];
    logic       cnt_en_o [4];
    logic       clken_o  [4];
    logic       busy_o   [4];
    logic       done_o   [4];
    logic       pass_o   [4];
    logic [7:0] sig_o    [4];
    logic [8:0] sbq [$];
    int total = 0;
    int bad   = 0;
`ifdef MISR_CO_CAPTURE_EN
    localparam logic [7:0] CARRY_EXP = 8'h10;
`else
    localparam logic [7:0] CARRY_EXP = 8'h00;
`endif

    always #5 clk = ~clk;

    count_sig_analyzer #(.TEST_CYCLES(4), .GOLDEN_SIG(8'h00), .SEED(8'h00)) u_a (
        .clk(clk), .rst(rst), .start(start_i[0]), .count(count), .co(co),
        .cnt_en(cnt_en_o[0]), .cnt_clk_en(clken_o[0]), .busy(busy_o[0]),
        .done(done_o[0]), .pass(pass_o[0]), .signature(sig_o[0]));
    count_sig_analyzer #(.TEST_CYCLES(2), .GOLDEN_SIG(8'h00), .SEED(8'h00)) u_b (
        .clk(clk), .rst(rst), .start(start_i[1]), .count(count), .co(co),
        .cnt_en(cnt_en_o[1]), .cnt_clk_en(clken_o[1]), .busy(busy_o[1]),
        .done(done_o[1]), .pass(pass_o[1]), .signature(sig_o[1]));
    count_sig_analyzer #(.TEST_CYCLES(1), .GOLDEN_SIG(8'h00), .SEED(8'h00)) u_c (
        .clk(clk), .rst(rst), .start(start_i[2]), .count(count), .co(co),
        .cnt_en(cnt_en_o[2]), .cnt_clk_en(clken_o[2]), .busy(busy_o[2]),
        .done(done_o[2]), .pass(pass_o[2]), .signature(sig_o[2]));
    count_sig_analyzer #(.TEST_CYCLES(16), .GOLDEN_SIG(8'hA5), .SEED(8'h00)) u_d (
        .clk(clk), .rst(rst), .start(start_i[3]), .count(count), .co(co),
        .cnt_en(cnt_en_o[3]), .cnt_clk_en(clken_o[3]), .busy(busy_o[3]),
        .done(done_o[3]), .pass(pass_o[3]), .signature(sig_o[3]));

    function automatic logic [7:0] misr(input logic [7:0] s, input logic [3:0] c, input logic o);
        logic cap;
`ifdef MISR_CO_CAPTURE_EN
        cap = o;
`else
        cap = 1'b0;
`endif
        return {s[6:0], 1'b0} ^ (s[7] ? 8'h1D : 8'h00) ^ {3'b000, cap, c};
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_cleared(input string tag);
        for (int k = 0; k < 4; k++) begin
            chk({tag, "_en"},    8'(cnt_en_o[k]), 8'h00);
            chk({tag, "_clken"}, 8'(clken_o[k]),  8'h00);
            chk({tag, "_busy"},  8'(busy_o[k]),   8'h00);
            chk({tag, "_done"},  8'(done_o[k]),   8'h00);
            chk({tag, "_pass"},  8'(pass_o[k]),   8'h00);
            chk({tag, "_sig"},   sig_o[k],        8'h00);
        end
    endtask

    // One complete run on analyzer k; expected result goes to the scoreboard, then is popped at DONE.
    task automatic run(input int k, input int n, input logic [63:0] cv, input logic [15:0] cov,
                       input logic [7:0] golden, input bit noisy);
        logic [7:0] m;
        logic [8:0] e;
        m = 8'h00;
        @(negedge clk); start_i[k] = 1'b1;
        @(negedge clk); start_i[k] = 1'b0;
        chk("load_busy", 8'(busy_o[k]),   8'h01);
        chk("load_done", 8'(done_o[k]),   8'h00);
        chk("load_pass", 8'(pass_o[k]),   8'h00);
        chk("load_en",   8'(cnt_en_o[k]), 8'h00);
        @(negedge clk);
        chk("run_seed", sig_o[k], m);
        for (int i = 0; i < n; i++) begin
            chk("run_en",    8'(cnt_en_o[k]), 8'h01);
            chk("run_clken", 8'(clken_o[k]),  8'h01);
            count = cv[4*i +: 4];
            co    = cov[i];
            start_i[k] = noisy & i[0];
            m = misr(m, count, co);
            @(negedge clk);
            chk("run_sig", sig_o[k], m);
        end
        start_i[k] = 1'b0;
        sbq.push_back({m == golden, m});
        chk("cmp_en",   8'(cnt_en_o[k]), 8'h00);
        chk("cmp_busy", 8'(busy_o[k]),   8'h01);
        chk("cmp_done", 8'(done_o[k]),   8'h00);
        @(negedge clk);
        e = sbq.pop_front();
        chk("done_flag", 8'(done_o[k]),   8'h01);
        chk("done_busy", 8'(busy_o[k]),   8'h00);
        chk("done_en",   8'(cnt_en_o[k]), 8'h00);
        chk("done_pass", 8'(pass_o[k]),   8'(e[8]));
        chk("done_sig",  sig_o[k],        e[7:0]);
        count = 4'h0;
        co    = 1'b0;
    endtask

    initial begin
        rst = 1'b0; count = 4'h0; co = 1'b0;
        for (int k = 0; k < 4; k++) start_i[k] = 1'b0;
        repeat (2) @(negedge clk);
        chk_cleared("por");
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk_cleared("idle_hold");
        run(0, 4, 64'h0, 16'h0, 8'h00, 1'b0);
        chk("zero_sig",  sig_o[0],        8'h00);
        chk("zero_pass", 8'(pass_o[0]),   8'h01);
        run(1, 2, 64'hA5, 16'h0, 8'h00, 1'b0);
        chk("cancel_sig",  sig_o[1],      8'h00);
        chk("cancel_pass", 8'(pass_o[1]), 8'h01);
        run(1, 2, {$urandom, $urandom}, 16'(($urandom)), 8'h00, 1'b1);
        run(2, 1, 64'h5, 16'h0, 8'h00, 1'b0);
        chk("mismatch_sig",  sig_o[2],      8'h05);
        chk("mismatch_pass", 8'(pass_o[2]), 8'h00);
        run(2, 1, 64'h0, 16'h1, 8'h00, 1'b0);
        chk("carry_sig", sig_o[2], CARRY_EXP);
        run(3, 16, {$urandom, $urandom}, 16'(($urandom)), 8'hA5, 1'b1);
        // abort D on its third RUN cycle; A..C sit in DONE at this point
        @(negedge clk); start_i[3] = 1'b1;
        @(negedge clk); start_i[3] = 1'b0;
        @(negedge clk); count = 4'h7; co = 1'b1;
        repeat (2) @(negedge clk);
        chk("pre_abort_en", 8'(cnt_en_o[3]), 8'h01);
        #2 rst = 1'b0;
        #1 chk_cleared("abort");
        @(negedge clk); rst = 1'b1; count = 4'h0; co = 1'b0;
        repeat (3) @(negedge clk);
        chk_cleared("post_abort");
        run(3, 16, {$urandom, $urandom}, 16'(($urandom)), 8'hA5, 1'b0);
        run(3, 16, 64'hFEDC_BA98_7654_3210, 16'hFFFF, 8'hA5, 1'b1);
        chk("sb_empty", 8'(sbq.size()), 8'h00);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
